moving_avg_filter: RTL

- Sample-processing stage between spi2adc (producer of 10-bit samples plus data_valid) and spi2dac/pwm (consumers of data_out).
- Box-car low-pass filter: each new ADC sample is accepted once, held in a circular buffer, and averaged with the previous 2^LOG2_TAPS-1 samples using a running sum.
- Drop-in alternative to the echo processors in the ECHOER slot; enable gives a registered bypass.

---
 rtl/moving_avg_filter_pkg.sv | 10 +
 rtl/rise_detect.sv | 22 ++
 rtl/moving_avg_filter.sv | 83 ++++++++
 3 files changed

// File: rtl/moving_avg_filter_pkg.sv
// Shared constants and types for the ADC -> processor -> DAC sample path.
package moving_avg_filter_pkg;

    localparam int SAMPLE_DW     = 10;
    localparam int LOG2_TAPS_MIN = 1;
    localparam int LOG2_TAPS_MAX = 6;

    typedef logic [SAMPLE_DW-1:0] sample_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: turns a level flag into a one-cycle accept strobe.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/moving_avg_filter.sv
// Box-car moving-average filter over the last 2^LOG2_TAPS accepted samples, with registered bypass.
module moving_avg_filter
    import moving_avg_filter_pkg::*;
#(
    parameter int LOG2_TAPS = 4,
    parameter int DW        = SAMPLE_DW
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic [DW-1:0] data_in,
    input  logic          data_valid,
    input  logic          enable,
    input  logic          clear,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          primed
);

    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int SW   = DW + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] FULL = (LOG2_TAPS + 1)'(TAPS);

    generate
        if (LOG2_TAPS < LOG2_TAPS_MIN || LOG2_TAPS > LOG2_TAPS_MAX) begin : g_bad_taps
            $error("moving_avg_filter: LOG2_TAPS out of range");
        end
    endgenerate

    logic [DW-1:0]        buffer [TAPS];
    logic [SW-1:0]        sum;
    logic [SW-1:0]        sum_next;
    logic [LOG2_TAPS-1:0] ptr;
    logic [LOG2_TAPS:0]   fill;
    logic [DW-1:0]        oldest;
    logic                 rise;

    rise_detect u_rise (
        .clk   (sysclk),
        .reset (reset),
        .level (data_valid),
        .rise  (rise)
    );

    // The evicted sample is always part of sum, so the subtraction never wraps.
    assign oldest   = buffer[ptr];
    assign sum_next = sum + SW'(data_in) - SW'(oldest);
    assign primed   = (fill == FULL);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            ptr       <= '0;
            fill      <= '0;
            // NOTE: the window lives in flops, not RAM, so every entry is reset to keep warm-up zero-filled.
            for (int i = 0; i < TAPS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                sum  <= '0;
                ptr  <= '0;
                fill <= '0;
                for (int i = 0; i < TAPS; i++) begin
                    buffer[i] <= '0;
                end
            end else if (rise) begin
                sum         <= sum_next;
                buffer[ptr] <= data_in;
                ptr         <= ptr + 1'b1;
                if (fill != FULL) begin
                    fill <= fill + 1'b1;
                end
                // Bypass still updates the window so re-enabling yields a valid average at once.
                data_out  <= enable ? DW'(sum_next >> LOG2_TAPS) : data_in;
                out_valid <= 1'b1;
            end
        end
    end

endmodule
